pla_vector_driver: RTL and testbench



---
 rtl/pla_vector_driver_if.sv | 27 ++
 rtl/pla_vector_driver.sv | 86 ++++++++
 tb/tb_pla_vector_driver.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/pla_vector_driver_if.sv
// rtl/pla_vector_driver_if.sv - control, PLA drive and result bundle for pla_vector_driver
interface pla_vector_driver_if #(
    parameter int NIN   = 22,
    parameter int SIG_W = 16
);
    logic             start;
    logic [NIN-1:0]   range_lo;
    logic [NIN-1:0]   range_hi;
    logic             hold;
    logic [NIN-1:0]   x;
    logic             y0;
    logic             busy;
    logic             done;
    logic             err_range;
    logic [NIN:0]     onset_cnt;
    logic [SIG_W-1:0] signature;

    modport master (
        output start, range_lo, range_hi, hold, y0,
        input  x, busy, done, err_range, onset_cnt, signature
    );

    modport slave (
        input  start, range_lo, range_hi, hold, y0,
        output x, busy, done, err_range, onset_cnt, signature
    );
endinterface

// File: rtl/pla_vector_driver.sv
// rtl/pla_vector_driver.sv - sweeps a minterm range into a PLA, counts onset and builds a MISR signature
module pla_vector_driver #(
    parameter int               NIN      = 22,
    parameter int               SIG_W    = 16,
    parameter logic [SIG_W-1:0] SIG_POLY = 16'h1021,
    parameter logic [SIG_W-1:0] SIG_SEED = 16'hFFFF
) (
    input  logic              clk,
    input  logic              rst_n,
    pla_vector_driver_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_n;
    logic [NIN-1:0]   x_q, x_n;
    logic [NIN-1:0]   hi_q, hi_n;
    logic [NIN:0]     cnt_q, cnt_n;
    logic [SIG_W-1:0] sig_q, sig_n;
    logic             err_q, err_n;
    logic             fb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            x_q     <= '0;
            hi_q    <= '0;
            cnt_q   <= '0;
            sig_q   <= SIG_SEED;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_n;
            x_q     <= x_n;
            hi_q    <= hi_n;
            cnt_q   <= cnt_n;
            sig_q   <= sig_n;
            err_q   <= err_n;
        end
    end

    always_comb begin
        state_n = state_q;
        x_n     = x_q;
        hi_n    = hi_q;
        cnt_n   = cnt_q;
        sig_n   = sig_q;
        err_n   = 1'b0;
        fb      = sig_q[SIG_W-1] ^ bus.y0;
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    // A rejected start leaves the previous results readable but drops done.
                    if (bus.range_lo > bus.range_hi) begin
                        err_n   = 1'b1;
                        state_n = IDLE;
                    end else begin
                        hi_n    = bus.range_hi;
                        x_n     = bus.range_lo;
                        cnt_n   = '0;
                        sig_n   = SIG_SEED;
                        state_n = RUN;
                    end
                end
            end
            RUN: begin
                if (!bus.hold) begin
                    cnt_n = cnt_q + {{NIN{1'b0}}, bus.y0};
                    sig_n = {sig_q[SIG_W-2:0], 1'b0} ^ (fb ? SIG_POLY : '0);
                    // Stop on hi rather than incrementing so a full-range sweep never wraps.
                    if (x_q == hi_q) begin
                        state_n = DONE;
                    end else begin
                        x_n = x_q + {{(NIN-1){1'b0}}, 1'b1};
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.x         = x_q;
    assign bus.busy      = (state_q == RUN);
    assign bus.done      = (state_q == DONE);
    assign bus.err_range = err_q;
    assign bus.onset_cnt = cnt_q;
    assign bus.signature = sig_q;
endmodule

// File: tb/tb_pla_vector_driver.sv
// tb/tb_pla_vector_driver.sv - scoreboard bench for pla_vector_driver
module tb_pla_vector_driver;
    logic clk;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;
    int   y0_mode  = 1;

    logic [22:0] exp_cnt_q[$];
    logic [15:0] exp_sig_q[$];
    logic [22:0] last_cnt;
    logic [15:0] last_sig;

    pla_vector_driver_if #(.NIN(22), .SIG_W(16)) vif ();

    pla_vector_driver #(
        .NIN(22), .SIG_W(16), .SIG_POLY(16'h1021), .SIG_SEED(16'hFFFF)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (vif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic pla_ref(input logic [21:0] v);
        return (^(v & 22'h1234A5)) ^ (v[7:4] == 4'hA);
    endfunction

    assign vif.y0 = (y0_mode == 1) ? 1'b1 : (y0_mode == 2) ? 1'b0 : pla_ref(vif.x);

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic [21:0] lo, input logic [21:0] hi,
                         output logic [22:0] cnt, output logic [15:0] sig);
        logic [21:0] v;
        logic        y;
        cnt = '0;
        sig = 16'hFFFF;
        v   = lo;
        while (1) begin
            y   = (y0_mode == 1) ? 1'b1 : (y0_mode == 2) ? 1'b0 : pla_ref(v);
            cnt = cnt + {22'd0, y};
            sig = {sig[14:0], 1'b0} ^ ((sig[15] ^ y) ? 16'h1021 : 16'h0000);
            if (v == hi) break;
            v = v + 22'd1;
        end
    endtask

    task automatic run_sweep(input logic [21:0] lo, input logic [21:0] hi,
                             input int hold_at, input int hold_len,
                             input int mid_start, input bit chk_x);
        logic [22:0] c;
        logic [15:0] s;
        logic [21:0] xexp;
        int          k;
        int          budget;
        bit          done_seen;
        @(negedge clk);
        vif.start    = 1'b1;
        vif.range_lo = lo;
        vif.range_hi = hi;
        model(lo, hi, c, s);
        exp_cnt_q.push_back(c);
        exp_sig_q.push_back(s);
        budget    = int'(hi - lo) + hold_len + 20;
        k         = 0;
        xexp      = lo;
        done_seen = 1'b0;
        while (k < budget) begin
            @(negedge clk);
            k++;
            if (k == 1) vif.start = 1'b0;
            if (vif.done) begin
                done_seen = 1'b1;
                break;
            end
            if (chk_x) begin
                check_eq("x_step", {42'd0, vif.x}, {42'd0, xexp});
                check_eq("busy_run", {63'd0, vif.busy}, 64'd1);
            end
            if (mid_start != 0 && k == mid_start) begin
                vif.start    = 1'b1;
                vif.range_lo = 22'd0;
                vif.range_hi = 22'd0;
            end
            if (mid_start != 0 && k == mid_start + 1) vif.start = 1'b0;
            if (hold_at != 0 && k == hold_at) vif.hold = 1'b1;
            if (hold_at != 0 && k == hold_at + hold_len) vif.hold = 1'b0;
            if (!vif.hold && xexp != hi) xexp = xexp + 22'd1;
        end
        vif.start = 1'b0;
        vif.hold  = 1'b0;
        check_eq("done_seen", {63'd0, done_seen}, 64'd1);
        check_eq("done_latency", 64'(k), 64'(int'(hi - lo) + 2 + hold_len));
        check_eq("x_final", {42'd0, vif.x}, {42'd0, hi});
        check_eq("busy_done", {63'd0, vif.busy}, 64'd0);
        last_cnt = exp_cnt_q.pop_front();
        last_sig = exp_sig_q.pop_front();
        check_eq("onset_cnt", {41'd0, vif.onset_cnt}, {41'd0, last_cnt});
        check_eq("signature", {48'd0, vif.signature}, {48'd0, last_sig});
    endtask

    task automatic reject(input logic [22:0] ecnt, input logic [15:0] esig, input logic [21:0] ex);
        @(negedge clk);
        vif.start    = 1'b1;
        vif.range_lo = 22'd8;
        vif.range_hi = 22'd7;
        @(negedge clk);
        vif.start = 1'b0;
        check_eq("err_pulse", {63'd0, vif.err_range}, 64'd1);
        check_eq("rej_busy", {63'd0, vif.busy}, 64'd0);
        check_eq("rej_done", {63'd0, vif.done}, 64'd0);
        @(negedge clk);
        check_eq("err_clear", {63'd0, vif.err_range}, 64'd0);
        check_eq("rej_busy2", {63'd0, vif.busy}, 64'd0);
        check_eq("rej_cnt", {41'd0, vif.onset_cnt}, {41'd0, ecnt});
        check_eq("rej_sig", {48'd0, vif.signature}, {48'd0, esig});
        check_eq("rej_x", {42'd0, vif.x}, {42'd0, ex});
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_x"}, {42'd0, vif.x}, 64'd0);
        check_eq({tag, "_busy"}, {63'd0, vif.busy}, 64'd0);
        check_eq({tag, "_done"}, {63'd0, vif.done}, 64'd0);
        check_eq({tag, "_err"}, {63'd0, vif.err_range}, 64'd0);
        check_eq({tag, "_cnt"}, {41'd0, vif.onset_cnt}, 64'd0);
        check_eq({tag, "_sig"}, {48'd0, vif.signature}, 64'hFFFF);
    endtask

    initial begin
        logic [22:0] dc;
        logic [15:0] ds;
        int          k;
        rst_n        = 1'b0;
        vif.start    = 1'b0;
        vif.range_lo = '0;
        vif.range_hi = '0;
        vif.hold     = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_vals("reset");
        rst_n = 1'b1;

        reject(23'd0, 16'hFFFF, 22'd0);

        y0_mode = 1;
        run_sweep(22'd0, 22'd9, 0, 0, 0, 1'b1);
        check_eq("cnt_0_9", {41'd0, vif.onset_cnt}, 64'd10);

        run_sweep(22'd5, 22'd5, 0, 0, 0, 1'b1);
        check_eq("single_sig_y1", {48'd0, vif.signature}, 64'hFFFE);
        check_eq("single_cnt_y1", {41'd0, vif.onset_cnt}, 64'd1);
        y0_mode = 2;
        run_sweep(22'd5, 22'd5, 0, 0, 0, 1'b1);
        check_eq("single_sig_y0", {48'd0, vif.signature}, 64'hEFDF);
        check_eq("single_cnt_y0", {41'd0, vif.onset_cnt}, 64'd0);

        y0_mode = 1;
        run_sweep(22'd3, 22'd6, 0, 0, 0, 1'b1);
        run_sweep(22'd3, 22'd6, 2, 2, 0, 1'b1);
        check_eq("stall_cnt", {41'd0, vif.onset_cnt}, 64'd4);
        reject(last_cnt, last_sig, 22'd6);

        y0_mode = 0;
        run_sweep(22'd100, 22'd400, 50, 3, 0, 1'b1);
        run_sweep(22'h3FFFF8, 22'h3FFFFF, 0, 0, 0, 1'b1);

        // Abort a long sweep with reset; its scoreboard entry is discarded.
        @(negedge clk);
        vif.start    = 1'b1;
        vif.range_lo = 22'd0;
        vif.range_hi = 22'd1023;
        model(22'd0, 22'd1023, dc, ds);
        exp_cnt_q.push_back(dc);
        exp_sig_q.push_back(ds);
        @(negedge clk);
        vif.start = 1'b0;
        k = 0;
        while (vif.x != 22'd100 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check_eq("reach_100", {42'd0, vif.x}, 64'd100);
        rst_n = 1'b0;
        #1;
        check_reset_vals("midreset");
        dc = exp_cnt_q.pop_front();
        ds = exp_sig_q.pop_front();
        @(negedge clk);
        rst_n = 1'b1;
        run_sweep(22'd0, 22'd1023, 0, 0, 5, 1'b0);
        check_eq("restart_cnt", {41'd0, vif.onset_cnt}, {41'd0, dc});
        check_eq("restart_sig", {48'd0, vif.signature}, {48'd0, ds});
        check_eq("sb_empty", 64'(exp_cnt_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
